// File: rtl/compress_pkg.sv
// Shared types and constants for the compressed-frame capture controller.
// Optional capture watchdog: define COMPRESS_CTRL_WATCHDOG_EN.
package compress_pkg;

  localparam int IMG_DIM   = 224;  // camera frame is IMG_DIM x IMG_DIM
  localparam int CMP_DIM   = 28;   // compressed frame is CMP_DIM x CMP_DIM
  localparam int CMP_CELLS = 784;  // CMP_DIM * CMP_DIM SRAM entries
  localparam int CMP_AW    = 10;   // SRAM address width
  localparam int PIX_AW    = 8;    // pixel row/column coordinate width

  // Address of the final compressed cell; its write completes the frame.
  localparam logic [CMP_AW-1:0] LAST_CELL = CMP_AW'(CMP_CELLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // True for the top-left pixel, which marks the start of a camera frame.
  function automatic logic is_frame_origin(input logic [PIX_AW-1:0] haddr,
                                           input logic [PIX_AW-1:0] vaddr);
    return (haddr == '0) && (vaddr == '0);
  endfunction

endpackage

// File: rtl/compress_frame_ctrl_watchdog.sv
// Capture watchdog: counts consecutive CAPTURE cycles without a compressor
// write and pulses o_expire on the TIMEOUT_CYC-th such cycle.
// Instantiated only when COMPRESS_CTRL_WATCHDOG_EN is defined.
module capture_watchdog
  import compress_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);

  logic [15:0] r_cnt;

  // Fires while the count shows TIMEOUT_CYC-1 earlier silent cycles,
  // i.e. on the TIMEOUT_CYC-th silent cycle itself.
  assign o_expire = i_run && !i_clear && (r_cnt == 16'(TIMEOUT_CYC - 1));

  // Idle-cycle counter; restarts on any write, outside CAPTURE, or on expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || i_clear || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/compress_frame_ctrl.sv
// Frame-capture controller: arms on capture_req, starts the compressor at
// pixel (0,0), forwards its 784 SRAM writes, then lends the SRAM port to the
// classifier until release_frame.
// Optional capture watchdog: define COMPRESS_CTRL_WATCHDOG_EN.
module compress_frame_ctrl
  import compress_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_req,
  input  logic              pix_valid,
  input  logic [PIX_AW-1:0] pix_haddr,
  input  logic [PIX_AW-1:0] pix_vaddr,
  output logic              comp_start,
  input  logic              comp_wr,
  input  logic [CMP_AW-1:0] comp_addr,
  input  logic [7:0]        comp_data,
  input  logic              rd_req,
  input  logic [CMP_AW-1:0] rd_addr,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              mem_we,
  output logic [CMP_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              frame_ready,
  input  logic              release_frame,
  output logic              busy,
  output logic              err_seq,
  output logic              err_timeout
);

  state_t            r_state;
  logic [CMP_AW-1:0] r_wcnt;
  logic              r_frame_ready;
  logic              r_busy;
  logic              r_rd_valid;
  logic              r_err_seq;
  logic              r_err_timeout;

  logic w_start;
  logic w_last_wr;
  logic w_expire;

  assign w_start   = (r_state == ST_ARM) && pix_valid &&
                     is_frame_origin(pix_haddr, pix_vaddr);
  assign w_last_wr = (r_state == ST_CAPTURE) && comp_wr && (r_wcnt == LAST_CELL);

`ifdef COMPRESS_CTRL_WATCHDOG_EN
  capture_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (r_state == ST_CAPTURE),
    .i_clear  (comp_wr),
    .o_expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_expire         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

  assign comp_start  = w_start;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_valid ? mem_rdata : 8'h00;
  assign frame_ready = r_frame_ready;
  assign busy        = r_busy;
  assign err_seq     = r_err_seq;
  assign err_timeout = r_err_timeout;

  // SRAM port owner: compressor during CAPTURE, classifier reads in DONE.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_CAPTURE: begin
        mem_we    = comp_wr;
        mem_addr  = comp_addr;
        mem_wdata = comp_data;
      end
      ST_DONE: begin
        if (rd_req) mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  // Capture FSM with registered status, read-valid and sticky error flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_frame_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      // busy and rd_valid trail the state they reflect by one cycle.
      r_busy     <= (r_state == ST_ARM) || (r_state == ST_CAPTURE);
      r_rd_valid <= (r_state == ST_DONE) && rd_req;

      case (r_state)
        ST_IDLE: begin
          if (comp_wr) r_err_seq <= 1'b1;
          if (capture_req) r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (comp_wr) r_err_seq <= 1'b1;
          if (w_start) begin
            r_state <= ST_CAPTURE;
            r_wcnt  <= '0;
          end
        end
        ST_CAPTURE: begin
          if (comp_wr) begin
            // Out-of-order writes are flagged but still land in the SRAM.
            if (comp_addr != r_wcnt) r_err_seq <= 1'b1;
            r_wcnt <= r_wcnt + 1'b1;
            if (w_last_wr) begin
              r_state       <= ST_DONE;
              r_frame_ready <= 1'b1;
            end
          end else if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_DONE: begin
          // Late compressor writes are dropped to protect the held frame.
          if (comp_wr) r_err_seq <= 1'b1;
          if (release_frame) begin
            r_state       <= ST_IDLE;
            r_frame_ready <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compress_frame_ctrl.sv
// Directed self-checking bench for compress_frame_ctrl. The DUT is built with
// TIMEOUT_CYC=100; the watchdog scenario follows COMPRESS_CTRL_WATCHDOG_EN.
module tb_compress_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       capture_req = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_haddr = '0;
  logic [7:0] pix_vaddr = '0;
  logic       comp_start;
  logic       comp_wr = 1'b0;
  logic [9:0] comp_addr = '0;
  logic [7:0] comp_data = '0;
  logic       rd_req = 1'b0;
  logic [9:0] rd_addr = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       frame_ready;
  logic       release_frame = 1'b0;
  logic       busy;
  logic       err_seq;
  logic       err_timeout;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_model [0:1023];

  compress_frame_ctrl #(
    .TIMEOUT_CYC (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture_req   (capture_req),
    .pix_valid     (pix_valid),
    .pix_haddr     (pix_haddr),
    .pix_vaddr     (pix_vaddr),
    .comp_start    (comp_start),
    .comp_wr       (comp_wr),
    .comp_addr     (comp_addr),
    .comp_data     (comp_data),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .frame_ready   (frame_ready),
    .release_frame (release_frame),
    .busy          (busy),
    .err_seq       (err_seq),
    .err_timeout   (err_timeout)
  );

  // 25 MHz clock.
  always #20 clk = ~clk;

  // Single-port SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    mem_rdata <= mem_model[mem_addr];
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #(40 * 60000);
    $display("FAIL sim_timeout: simulation did not finish within 60000 cycles");
    $fatal(1);
  end

  function automatic logic [7:0] data_of(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Arms, starts and feeds one compressed frame. skip_at replaces the write
  // address at that index with index+1; abort_at stops before that write.
  task automatic capture_frame(input int skip_at, input int abort_at,
                               output int starts, output int good_wr,
                               output logic fr_pre, output logic busy_arm);
    starts  = 0;
    good_wr = 0;
    fr_pre  = 1'bx;
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    // Tail of the previous camera frame while armed.
    pix_valid = 1'b1; pix_haddr = 8'd223; pix_vaddr = 8'd223;
    #1;
    if (comp_start) starts++;
    tick();
    busy_arm = busy;
    pix_haddr = 8'd0; pix_vaddr = 8'd0;
    #1;
    if (comp_start) starts++;
    tick();
    for (int i = 0; i < 784; i++) begin
      if (i == abort_at) break;
      if (i % 100 == 50) begin
        comp_wr = 1'b0; pix_valid = 1'b0;
        #1;
        if (comp_start) starts++;
        tick();
      end
      comp_wr     = 1'b1;
      comp_addr   = (i == skip_at) ? 10'(i + 1) : 10'(i);
      comp_data   = data_of(i);
      pix_valid   = 1'b1;
      pix_haddr   = 8'(i % 8);
      pix_vaddr   = 8'(i / 8);
      capture_req = (i == 100);
      #1;
      if (comp_start) starts++;
      if (mem_we === 1'b1 && mem_addr === comp_addr && mem_wdata === comp_data) good_wr++;
      if (i == 783) fr_pre = frame_ready;
      tick();
    end
    comp_wr = 1'b0; comp_addr = '0; comp_data = '0;
    pix_valid = 1'b0; pix_haddr = '0; pix_vaddr = '0; capture_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({comp_start, rd_valid, rd_data, mem_we, mem_addr, mem_wdata, frame_ready,
         busy, err_seq, err_timeout} !== 33'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ws=%b rv=%b rd=%h we=%b a=%h wd=%h fr=%b b=%b es=%b et=%b, expected all 0",
               comp_start, rd_valid, rd_data, mem_we, mem_addr, mem_wdata, frame_ready,
               busy, err_seq, err_timeout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_capture(input string tag);
    int starts, good;
    logic fr_pre, busy_arm;
    capture_frame(-1, -1, starts, good, fr_pre, busy_arm);
    total++;
    if (busy_arm !== 1'b1) begin bad++; $display("FAIL %s busy_in_arm: got %b expected 1", tag, busy_arm); end
    total++;
    if (starts !== 1) begin bad++; $display("FAIL %s comp_start_count: got %0d expected 1", tag, starts); end
    total++;
    if (good !== 784) begin bad++; $display("FAIL %s forwarded_writes: got %0d expected 784", tag, good); end
    total++;
    if (fr_pre !== 1'b0) begin bad++; $display("FAIL %s frame_ready_at_last_write: got %b expected 0", tag, fr_pre); end
    total++;
    if (frame_ready !== 1'b1) begin bad++; $display("FAIL %s frame_ready_after: got %b expected 1", tag, frame_ready); end
    total++;
    if ({err_seq, err_timeout} !== 2'b00) begin
      bad++; $display("FAIL %s errors: got %b%b expected 00", tag, err_seq, err_timeout);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_lag: got %b expected 1", tag, busy); end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_done: got %b expected 0", tag, busy); end
  endtask

  task automatic test_readback;
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd5; addrs[2] = 10'd783;
    for (int k = 0; k <= 3; k++) begin
      rd_req  = (k < 3);
      rd_addr = (k < 3) ? addrs[k] : 10'd0;
      #1;
      total++;
      if (mem_we !== 1'b0) begin bad++; $display("FAIL readback_we_%0d: got %b expected 0", k, mem_we); end
      if (k < 3) begin
        total++;
        if (mem_addr !== addrs[k]) begin
          bad++; $display("FAIL readback_addr_%0d: got %0d expected %0d", k, mem_addr, addrs[k]);
        end
      end
      if (k > 0) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== data_of(int'(addrs[k-1]))) begin
          bad++;
          $display("FAIL readback_data_%0d: got v=%b d=%h expected v=1 d=%h",
                   k, rd_valid, rd_data, data_of(int'(addrs[k-1])));
        end
      end
      tick();
    end
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL readback_valid_end: got %b expected 0", rd_valid); end
  endtask

  task automatic test_arm_ignored_in_done;
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    tick(); tick();
    pix_valid = 1'b1; pix_haddr = 8'd0; pix_vaddr = 8'd0;
    #1;
    total++;
    if ({busy, frame_ready, comp_start} !== 3'b010) begin
      bad++; $display("FAIL arm_in_done: got busy/fr/start=%b%b%b expected 010", busy, frame_ready, comp_start);
    end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_release_with_read;
    rd_req = 1'b1; rd_addr = 10'd5; release_frame = 1'b1;
    #1;
    total++;
    if (mem_addr !== 10'd5) begin bad++; $display("FAIL release_read_addr: got %0d expected 5", mem_addr); end
    tick();
    rd_req = 1'b0; rd_addr = '0; release_frame = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== data_of(5) || frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL release_read: got v=%b d=%h fr=%b expected v=1 d=%h fr=0",
               rd_valid, rd_data, frame_ready, data_of(5));
    end
    tick();
    // IDLE ignores the frame origin, so no start may appear.
    pix_valid = 1'b1; pix_haddr = 8'd0; pix_vaddr = 8'd0;
    #1;
    total++;
    if ({rd_valid, busy, comp_start} !== 3'b000) begin
      bad++; $display("FAIL release_idle: got v/busy/start=%b%b%b expected 000", rd_valid, busy, comp_start);
    end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_seq_fault;
    int starts, good;
    logic fr_pre, busy_arm;
    total++;
    if (err_seq !== 1'b0) begin bad++; $display("FAIL seq_pre: got %b expected 0", err_seq); end
    capture_frame(6, -1, starts, good, fr_pre, busy_arm);
    total++;
    if (good !== 784) begin bad++; $display("FAIL seq_forwarded: got %0d expected 784", good); end
    total++;
    if (err_seq !== 1'b1 || frame_ready !== 1'b1) begin
      bad++; $display("FAIL seq_flag: got es=%b fr=%b expected es=1 fr=1", err_seq, frame_ready);
    end
    release_frame = 1'b1;
    tick();
    release_frame = 1'b0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_capture;
    int starts, good;
    logic fr_pre, busy_arm;
    capture_frame(-1, 400, starts, good, fr_pre, busy_arm);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b expected 1", busy); end
    pulse_reset();
    total++;
    if ({comp_start, rd_valid, rd_data, mem_we, mem_addr, mem_wdata, frame_ready,
         busy, err_seq, err_timeout} !== 33'd0) begin
      bad++;
      $display("FAIL abort_outputs: got ws=%b rv=%b rd=%h we=%b a=%h wd=%h fr=%b b=%b es=%b et=%b, expected all 0",
               comp_start, rd_valid, rd_data, mem_we, mem_addr, mem_wdata, frame_ready,
               busy, err_seq, err_timeout);
    end
    pix_valid = 1'b1; pix_haddr = 8'd0; pix_vaddr = 8'd0;
    #1;
    total++;
    if (comp_start !== 1'b0) begin bad++; $display("FAIL abort_idle_start: got %b expected 0", comp_start); end
    pix_valid = 1'b0;
    tick();
    test_full_capture("recapture");
  endtask

  task automatic test_done_write;
    comp_wr = 1'b1; comp_addr = 10'd3; comp_data = 8'hAA;
    #1;
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL done_write_we: got %b expected 0", mem_we); end
    tick();
    comp_wr = 1'b0; comp_addr = '0; comp_data = '0;
    total++;
    if (err_seq !== 1'b1 || frame_ready !== 1'b1) begin
      bad++; $display("FAIL done_write_flag: got es=%b fr=%b expected es=1 fr=1", err_seq, frame_ready);
    end
    rd_req = 1'b1; rd_addr = 10'd3;
    tick();
    rd_req = 1'b0; rd_addr = '0;
    total++;
    if (rd_data !== data_of(3)) begin
      bad++; $display("FAIL done_write_protect: got %h expected %h", rd_data, data_of(3));
    end
    release_frame = 1'b1;
    tick();
    release_frame = 1'b0;
  endtask

  task automatic test_idle_write;
    pulse_reset();
    comp_wr = 1'b1; comp_addr = 10'd0; comp_data = 8'h55;
    #1;
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL idle_write_we: got %b expected 0", mem_we); end
    tick();
    comp_wr = 1'b0; comp_data = '0;
    total++;
    if (err_seq !== 1'b1) begin bad++; $display("FAIL idle_write_flag: got %b expected 1", err_seq); end
    pulse_reset();
  endtask

  task automatic test_watchdog;
    int starts, good;
    logic fr_pre, busy_arm;
    capture_frame(-1, 10, starts, good, fr_pre, busy_arm);
`ifdef COMPRESS_CTRL_WATCHDOG_EN
    repeat (99) tick();
    total++;
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_early: got %b expected 0", err_timeout); end
    tick();
    total++;
    if (err_timeout !== 1'b1 || frame_ready !== 1'b0) begin
      bad++; $display("FAIL wd_expire: got et=%b fr=%b expected et=1 fr=0", err_timeout, frame_ready);
    end
    pix_valid = 1'b1; pix_haddr = 8'd0; pix_vaddr = 8'd0;
    #1;
    total++;
    if (comp_start !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL wd_idle: got start=%b we=%b expected 0 0", comp_start, mem_we);
    end
    pix_valid = 1'b0;
`else
    repeat (200) tick();
    total++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL wd_off_wait: got et=%b busy=%b expected et=0 busy=1", err_timeout, busy);
    end
    comp_wr = 1'b1; comp_addr = 10'd10; comp_data = data_of(10);
    #1;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd10) begin
      bad++; $display("FAIL wd_off_capture: got we=%b a=%0d expected we=1 a=10", mem_we, mem_addr);
    end
    comp_wr = 1'b0; comp_addr = '0; comp_data = '0;
`endif
    tick();
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_full_capture("full");
    test_readback();
    test_arm_ignored_in_done();
    test_release_with_read();
    test_seq_fault();
    pulse_reset();
    test_reset_mid_capture();
    test_done_write();
    test_idle_write();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compress_frame_ctrl.md
# compress_frame_ctrl

Frame-capture controller that sequences the 224x224 to 28x28 image compressor and owns the single-port 784x8 compressed-image SRAM. It arms on a capture request, starts the compressor on the first pixel of the next frame, and tracks the compressor's 784 writes. It then holds the finished frame and hands the SRAM port to the classifier for reads until the frame is released. It sits between the camera pixel stream, `image_compressor`, the compressed SRAM and the classifier.

## Interface
- `TIMEOUT_CYC`, 16384: max cycles between compressor writes during capture (watchdog build only).
- `clk`  in  1: 25 MHz system clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `capture_req`  in  1: single-cycle request to capture the next frame.
- `pix_valid`  in  1: camera pixel qualifier.
- `pix_haddr`  in  8: pixel column, 0..223.
- `pix_vaddr`  in  8: pixel row, 0..223.
- `comp_start`  out  1: start strobe to the compressor.
- `comp_wr`  in  1: compressor write strobe.
- `comp_addr`  in  10: compressor write address.
- `comp_data`  in  8: compressor write data.
- `rd_req`  in  1: classifier read request.
- `rd_addr`  in  10: classifier read address.
- `rd_valid`  out  1: read data valid.
- `rd_data`  out  8: read data.
- `mem_we`  out  1: SRAM write enable.
- `mem_addr`  out  10: SRAM address.
- `mem_wdata`  out  8: SRAM write data.
- `mem_rdata`  in  8: SRAM read data; 1-cycle latency.
- `frame_ready`  out  1: compressed frame complete and readable.
- `release_frame`  in  1: classifier done with the frame.
- `busy`  out  1: high in ARM or CAPTURE.
- `err_seq`  out  1: sticky flag; out-of-order or unexpected compressor write.
- `err_timeout`  out  1: sticky flag; capture watchdog expired.

## Operation
- FSM states: IDLE, ARM, CAPTURE, DONE. Reset state is IDLE.
- Reset values: all outputs 0; write counter `wcnt` 0; watchdog 0.
- IDLE:
  - `capture_req` goes to ARM.
  - Compressor writes in IDLE set `err_seq` and are not forwarded.
- ARM:
  - The start condition is `pix_valid` with `pix_haddr`=0 and `pix_vaddr`=0.
  - On that cycle `comp_start`=1 (combinational) and the FSM goes to CAPTURE. `wcnt` clears.
  - `capture_req` is ignored outside IDLE.
- CAPTURE:
  - `mem_we`=`comp_wr`, `mem_addr`=`comp_addr`, `mem_wdata`=`comp_data`, all combinational pass-through.
  - Each `comp_wr` compares `comp_addr` with `wcnt`. A mismatch sets `err_seq`; the write is still forwarded.
  - `wcnt` increments on each `comp_wr`.
  - A write with `wcnt`=783 goes to DONE.
  - `comp_start` is never reasserted in CAPTURE, even at pixel (0,0).
- DONE:
  - `frame_ready`=1.
  - The SRAM port belongs to the reader: `mem_addr`=`rd_addr` while `rd_req`, `mem_we`=0.
  - `rd_valid` is `rd_req` delayed one cycle; `rd_data`=`mem_rdata` when `rd_valid`.
  - `comp_wr` in DONE sets `err_seq` and is dropped, so the frame is protected.
  - `release_frame` goes to IDLE. If `rd_req` arrives in the same cycle, that read is still issued and its `rd_valid` appears in IDLE on the next cycle.
- `rd_req` outside DONE is ignored: no `rd_valid`, `mem_addr` not driven from `rd_addr`.
- Sticky errors clear only on reset.
- Reset mid-CAPTURE aborts the capture. The SRAM contents are undefined and `frame_ready` stays 0 until the next full capture.

## Timing
- `capture_req` to ARM: 1 cycle.
- Pixel (0,0) in ARM to `comp_start`: same cycle. CAPTURE is entered on the next edge.
- Final write (`wcnt`=783) to `frame_ready`=1: 1 cycle.
- `rd_req` at edge N gives `rd_valid`/`rd_data` at edge N+1. Back-to-back reads run at one per cycle.
- `release_frame` to `frame_ready`=0: 1 cycle.
- `busy` is registered and follows the state: high the cycle after entering ARM, low the cycle after leaving CAPTURE.

## Configuration
- `COMPRESS_CTRL_WATCHDOG_EN` defined:
  - A 16-bit counter runs in CAPTURE and clears on every `comp_wr`.
  - When it reaches `TIMEOUT_CYC` it sets `err_timeout` and the FSM goes to IDLE, with no `frame_ready`.
- Undefined: no counter; `err_timeout` is tied to 0; CAPTURE waits indefinitely.

## Structure
- Package `compress_pkg`:
  - `typedef enum` for the states above.
  - Constants `IMG_DIM`=224, `CMP_DIM`=28, `CMP_CELLS`=784, `CMP_AW`=10.
- One sub-module, `capture_watchdog` (counter, clear, expire pulse), instantiated only under the macro.
- The SRAM port mux and the FSM stay in the top-level module.

## Test plan
- Full capture: `capture_req`, then a 224x224 stream with 400-cycle line gaps and the compressor model writing addresses 0..783.
  - Required: `comp_start` exactly once, at (0,0); 784 `mem_we` pulses at addresses 0..783; `frame_ready`=1 one cycle after the last write; no errors.
- Readback: in DONE, `rd_req` on 3 consecutive cycles with `rd_addr` 0, 5, 783.
  - Required: `rd_valid` on the 3 following cycles; `rd_data` equals the stored values; `mem_we`=0 throughout.
- Sequencing faults:
  - Compressor writes address 7 when `wcnt`=6: `err_seq`=1 and the write is forwarded.
  - `comp_wr` in DONE: no `mem_we`, `err_seq`=1.
- Arming and release:
  - `capture_req` while in CAPTURE or DONE: no state change.
  - `release_frame` and `rd_req` in the same cycle: `rd_valid` the next cycle, state IDLE, `frame_ready`=0.
- Watchdog, macro defined with `TIMEOUT_CYC`=100: stop compressor writes after write 10.
  - Required: `err_timeout`=1 at the 100th idle cycle, state IDLE, `frame_ready`=0.
  - Macro undefined: FSM stays in CAPTURE.
- Reset: assert `rst_n`=0 for one edge at write 400 of a capture.
  - Required: state IDLE; all outputs 0; a subsequent full capture passes.
